// File: rtl/transponder_pkg.sv
// Shared constants for the quiz-buzzer front end: channel indices and default timing.
package transponder_pkg;

  localparam int NUM_CH  = 4;
  localparam int CH_CON0 = 0;
  localparam int CH_CON1 = 1;
  localparam int CH_CON2 = 2;
  localparam int CH_HOST = 3;

  // 20 ms debounce and 5 s stuck threshold at a 50 MHz clock
  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_STUCK_CYCLES    = 250000000;

endpackage

// File: rtl/key_debounce_channel.sv
// One button channel: 2-FF synchroniser, polarity fix, debounce counter,
// press/release pulse generation and held-too-long detection.
module key_debounce_channel
  import transponder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
  parameter int STUCK_CYCLES     = DEF_STUCK_CYCLES,
  parameter bit INPUT_ACTIVE_LOW = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press,
  output logic lift,
  output logic stuck
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = $clog2(STUCK_CYCLES + 1);
  localparam logic          INACTIVE = INPUT_ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] HOLD_MAX = SW'(STUCK_CYCLES);

  logic          sync1;
  logic          sync2;
  logic          sample;
  logic [CW-1:0] cnt;
  logic [SW-1:0] hold;
  logic          drop;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= INACTIVE;
      sync2 <= INACTIVE;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  assign sample = INPUT_ACTIVE_LOW ? ~sync2 : sync2;

  // Any sample matching the current level restarts the stability count
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      lift  <= 1'b0;
    end else begin
      press <= 1'b0;
      lift  <= 1'b0;
      if (sample == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sample;
        press <= sample;
        lift  <= ~sample;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign drop = level && (sample != level) && (cnt == CNT_LAST);

  // Hold counter clears on the very edge the level falls, so stuck drops with it
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold <= '0;
    end else if (drop || !level) begin
      hold <= '0;
    end else if (hold != HOLD_MAX) begin
      hold <= hold + 1'b1;
    end
  end

  assign stuck = (hold == HOLD_MAX);

endmodule

// File: rtl/key_conditioner.sv
// Conditions the three contestant buttons and the host button into clean
// levels, single-cycle press/release pulses and stuck flags.
module key_conditioner
  import transponder_pkg::*;
#(
  parameter int CHANNELS         = NUM_CH,
  parameter int DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
  parameter int STUCK_CYCLES     = DEF_STUCK_CYCLES,
  parameter bit INPUT_ACTIVE_LOW = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] btn_raw,
  output logic [CHANNELS-1:0] btn_level,
  output logic [CHANNELS-1:0] btn_press,
  output logic [CHANNELS-1:0] btn_release,
  output logic                any_press,
  output logic [CHANNELS-1:0] btn_stuck
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    key_debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .STUCK_CYCLES    (STUCK_CYCLES),
      .INPUT_ACTIVE_LOW(INPUT_ACTIVE_LOW)
    ) u_ch (
      .clock(clock),
      .reset(reset),
      .raw  (btn_raw[i]),
      .level(btn_level[i]),
      .press(btn_press[i]),
      .lift (btn_release[i]),
      .stuck(btn_stuck[i])
    );
  end

  assign any_press = |btn_press;

endmodule

// File: tb/tb_key_conditioner.sv
// Randomised and directed bench for key_conditioner against a sample-history
// reference model (level flips once the last DEB samples all disagree with it).
module tb_key_conditioner;
  import transponder_pkg::*;

  localparam int DEB = 4;
  localparam int STK = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] btn_raw = 4'hF;
  logic [3:0] btn_level, btn_press, btn_release, btn_stuck;
  logic       any_press;

  int check_count = 0;
  int error_count = 0;
  int edge_num = 0;

  bit [3:0] m_sync1, m_sync2, m_level, m_press, m_release, m_stuck;
  bit [7:0] m_hist [4];
  int       m_held [4];

  always #5 clock = ~clock;

  key_conditioner #(
    .CHANNELS(4), .DEBOUNCE_CYCLES(DEB), .STUCK_CYCLES(STK), .INPUT_ACTIVE_LOW(1'b1)
  ) dut (
    .clock(clock), .reset(reset), .btn_raw(btn_raw), .btn_level(btn_level),
    .btn_press(btn_press), .btn_release(btn_release), .any_press(any_press),
    .btn_stuck(btn_stuck)
  );

  function automatic void model_reset();
    m_sync1 = 4'hF;
    m_sync2 = 4'hF;
    m_level = '0;
    m_press = '0;
    m_release = '0;
    m_stuck = '0;
    for (int c = 0; c < 4; c++) begin
      m_hist[c] = '0;
      m_held[c] = 0;
    end
  endfunction

  // One clock edge: the debouncer sees the already-synchronised, inverted pin
  function automatic void model_edge();
    bit [3:0] s;
    bit       was, all_diff;
    s = ~m_sync2;
    m_press = '0;
    m_release = '0;
    for (int c = 0; c < 4; c++) begin
      was = m_level[c];
      m_hist[c] = {m_hist[c][6:0], s[c]};
      all_diff = 1'b1;
      for (int k = 0; k < DEB; k++)
        if (m_hist[c][k] == was) all_diff = 1'b0;
      if (all_diff) begin
        m_level[c] = ~was;
        m_press[c] = ~was;
        m_release[c] = was;
      end
      if (was && m_level[c]) m_held[c] = (m_held[c] + 1 > STK) ? STK : m_held[c] + 1;
      else m_held[c] = 0;
      m_stuck[c] = (m_held[c] >= STK);
    end
    m_sync2 = m_sync1;
    m_sync1 = btn_raw;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s at edge %0d: got %0h, expected %0h", tag, edge_num, observed, expected);
    end
  endtask

  task automatic compare_all();
    checkOutput("level", btn_level, m_level);
    checkOutput("press", btn_press, m_press);
    checkOutput("release", btn_release, m_release);
    checkOutput("stuck", btn_stuck, m_stuck);
    checkOutput("any_press", any_press, |m_press);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    edge_num++;
    if (reset) model_edge();
    else model_reset();
    compare_all();
  endtask

  task automatic applyStimulus(input logic [3:0] raw, input int cycles);
    btn_raw = raw;
    repeat (cycles) step();
  endtask

  task automatic run_count(input logic [3:0] raw, input int cycles, input int ch,
                           output int presses, output int releases);
    btn_raw = raw;
    presses = 0;
    releases = 0;
    repeat (cycles) begin
      step();
      if (btn_press[ch]) presses++;
      if (btn_release[ch]) releases++;
    end
  endtask

  initial begin
    int  np, nr, rise_edge, any_cnt, press_edge;
    bit  found, prev_stuck;
    logic [3:0] raw;

    model_reset();
    #2;
    compare_all();
    repeat (3) step();
    reset = 1'b1;
    edge_num = 0;

    // Clean press on contestant 1: captured at edge 10, level at edge 15
    applyStimulus(4'hF, 9);
    applyStimulus(4'b1101, 5);
    checkOutput("t1_before", btn_press[1], 1'b0);
    step();
    checkOutput("t1_press", btn_press[1], 1'b1);
    checkOutput("t1_level", btn_level[1], 1'b1);
    checkOutput("t1_any", any_press, 1'b1);
    step();
    checkOutput("t1_press_end", btn_press[1], 1'b0);
    checkOutput("t1_any_end", any_press, 1'b0);

    // Bounce on contestant 0, then held
    run_count(4'b1100, 2, 0, np, nr);
    any_cnt = np;
    run_count(4'b1101, 2, 0, np, nr);
    any_cnt += np;
    run_count(4'b1100, 2, 0, np, nr);
    any_cnt += np;
    run_count(4'b1101, 2, 0, np, nr);
    any_cnt += np;
    checkOutput("t2_bounce_quiet", any_cnt, 0);
    run_count(4'b1100, 5, 0, np, nr);
    checkOutput("t2_early", np, 0);
    step();
    checkOutput("t2_press", btn_press[0], 1'b1);

    // Contestant 2: press, short glitch, then real release
    applyStimulus(4'b1000, 8);
    checkOutput("t3_held", btn_level[2], 1'b1);
    run_count(4'b1100, 3, 2, np, nr);
    checkOutput("t3_glitch_a", nr, 0);
    run_count(4'b1000, 6, 2, np, nr);
    checkOutput("t3_glitch_b", nr, 0);
    run_count(4'b1100, 8, 2, np, nr);
    checkOutput("t3_release", nr, 1);
    checkOutput("t3_level", btn_level[2], 1'b0);

    // All four pressed on the same edge
    applyStimulus(4'hF, 8);
    btn_raw = 4'h0;
    found = 0;
    rise_edge = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      step();
      if (any_press) begin
        found = 1;
        rise_edge = edge_num;
        checkOutput("t4_all", btn_press, 4'hF);
      end
    end
    checkOutput("t4_seen", found, 1);
    any_cnt = 0;
    repeat (8) begin
      step();
      if (any_press) any_cnt++;
    end
    checkOutput("t4_any_once", any_cnt, 0);

    // Host held until stuck, then released
    found = 0;
    while (!found && edge_num < rise_edge + 40) begin
      if (btn_stuck[3]) found = 1;
      else step();
    end
    checkOutput("t5_stuck_seen", found, 1);
    checkOutput("t5_stuck_delay", edge_num - rise_edge, STK);
    btn_raw = 4'b1000;
    found = 0;
    prev_stuck = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      prev_stuck = btn_stuck[3];
      step();
      if (!btn_level[3]) found = 1;
    end
    checkOutput("t5_fall_seen", found, 1);
    checkOutput("t5_stuck_before", prev_stuck, 1'b1);
    checkOutput("t5_stuck_clear", btn_stuck[3], 1'b0);

    // Reset mid-hold, then release it with contestant 0 still held
    applyStimulus(4'b1110, 10);
    @(negedge clock);
    reset = 1'b0;
    #1;
    model_reset();
    compare_all();
    checkOutput("t6_zero", {btn_level, btn_press, btn_release, btn_stuck}, 16'h0);
    applyStimulus(4'b1110, 2);
    reset = 1'b1;
    edge_num = 0;
    run_count(4'b1110, 5, 0, np, nr);
    checkOutput("t6_early", np, 0);
    step();
    checkOutput("t6_press", btn_press[0], 1'b1);
    run_count(4'b1110, 6, 0, np, nr);
    checkOutput("t6_single", np, 0);

    // Random pins: fast chatter first, then slower changes that allow stuck
    raw = btn_raw;
    for (int i = 0; i < 700; i++) begin
      for (int c = 0; c < 4; c++)
        if ($urandom_range(0, (i < 300) ? 3 : 30) == 0) raw[c] = ~raw[c];
      if (i == 350) begin
        @(negedge clock);
        reset = 1'b0;
        #1;
        model_reset();
        compare_all();
      end
      if (i == 353) reset = 1'b1;
      applyStimulus(raw, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Front-end conditioning stage for the quiz-buzzer system. It takes the three raw contestant push-buttons and the host button, synchronises and debounces each one, and delivers clean per-channel levels plus single-cycle press/release pulses. The contestant outputs drive the `con0..con2` inputs of the first-press arbiter and countdown; the host output drives round start/clear. There is no arbitration here: the arbiter downstream resolves simultaneous presses.

## Interface
- `CHANNELS`, 4: number of buttons. Index 0..2 are contestants 0..2; index 3 is the host.
- `DEBOUNCE_CYCLES`, 1000000: stable cycles required before a level change (20 ms at 50 MHz). Legal range is 1 or more.
- `STUCK_CYCLES`, 250000000: held-active cycles before a stuck flag is raised (5 s). Must be greater than `DEBOUNCE_CYCLES`.
- `INPUT_ACTIVE_LOW`, 1: when 1, the raw pins are inverted before use. Outputs are always active-high.

Ports:
- `clock`  in  1: single system clock.
- `reset`  in  1: asynchronous, active-low reset.
- `btn_raw`  in  CHANNELS: asynchronous raw button pins.
- `btn_level`  out  CHANNELS: debounced pressed level.
- `btn_press`  out  CHANNELS: one-cycle pulse on each debounced 0→1 transition.
- `btn_release`  out  CHANNELS: one-cycle pulse on each debounced 1→0 transition.
- `any_press`  out  1: OR of `btn_press`.
- `btn_stuck`  out  CHANNELS: channel held active for at least `STUCK_CYCLES`.

## Operation
- Each channel runs the following chain: a 2-FF synchroniser, then polarity normalisation, then the debounce counter, then the stuck counter.
- Synchroniser flops reset to the inactive pin value (1 when `INPUT_ACTIVE_LOW`=1).
- Debounce rule, evaluated every edge using `s` (the synchronised, normalised sample) and `cnt`:
  - If `s == btn_level`: set `cnt` to 0.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: toggle `btn_level`, set `cnt` to 0, and pulse press or release according to the new level.
  - Else: increment `cnt`.
- Any bounce that returns `s` to the current level restarts the count from 0.
- Counter width is `$clog2(DEBOUNCE_CYCLES+1)`. The counter never exceeds `DEBOUNCE_CYCLES-1`, so it cannot wrap.
- Stuck counter:
  - Counts while `btn_level`=1 and saturates at `STUCK_CYCLES`.
  - `btn_stuck` is asserted while the count equals `STUCK_CYCLES`.
  - The counter and flag clear in the same edge that drops `btn_level`.
  - Press and release pulses are unaffected by the stuck flag.
- Channels are fully independent. Any subset may pulse in the same cycle.
- `any_press` is combinational from the registered `btn_press`.

## Timing
- Reset values while `reset`=0: every `btn_level`, `btn_press`, `btn_release` and `btn_stuck` is 0, every counter is 0, and the synchronisers hold the inactive value.
- Latency: when a raw change is captured by the first synchroniser flop at edge E and then held stable, `btn_level` and the pulse update at edge E+1+`DEBOUNCE_CYCLES`.
- The release path has the same latency.
- `btn_press` and `btn_release` are exactly one cycle wide and are registered in the same edge as the `btn_level` update.
- Reset asserted mid-count or mid-hold clears the channel immediately. No release pulse is generated.
- A button held through reset deassertion produces one `btn_press`, at the normal latency measured from the first capture after reset.
- A raw glitch shorter than `DEBOUNCE_CYCLES` cycles (after synchronisation) produces no level change and no pulse.
- `btn_stuck` rises at the `STUCK_CYCLES`-th edge after the edge where `btn_level` rose.

## Structure
- Shared package `transponder_pkg` holds:
  - channel index constants `CH_CON0`=0, `CH_CON1`=1, `CH_CON2`=2, `CH_HOST`=3, and `NUM_CH`=4;
  - `DEF_DEBOUNCE_CYCLES` and `DEF_STUCK_CYCLES`.
- Sub-module `key_debounce_channel` contains one channel's synchroniser, polarity normalisation, debounce counter, stuck counter and pulse generation.
- `key_conditioner` instantiates `CHANNELS` copies of `key_debounce_channel` with a generate loop and forms `any_press`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `STUCK_CYCLES`=16 and `INPUT_ACTIVE_LOW`=1.

1. Clean press: drive `btn_raw[1]` to 0 before edge 10, then hold it. Required: `btn_level[1]` rises and `btn_press[1]` is 1 for one cycle at edge 15; `any_press`=1 in that same cycle only.
2. Bounce: toggle `btn_raw[0]` as 0,1,0,1 on successive 2-cycle intervals, then hold 0. Required: no pulse during the bouncing; a single `btn_press[0]` at 5 edges after the final stable capture.
3. Release and short glitch:
   - Held channel 2 returns to 1 for 3 cycles, then back to 0. Required: no `btn_release[2]`.
   - Channel 2 released for 8 cycles. Required: exactly one `btn_release[2]` and `btn_level[2]`=0.
4. Simultaneous press: drive all four raw bits to 0 on the same edge. Required: all `btn_press` bits pulse together in one cycle; `any_press` is high for 1 cycle.
5. Stuck:
   - Hold channel 3. Required: `btn_stuck[3]` rises 16 edges after `btn_level[3]` rose.
   - Release channel 3. Required: `btn_stuck[3]` clears in the same edge that `btn_level[3]` falls.
6. Reset mid-operation:
   - Assert `reset`=0 while channel 0 is pressed. Required: all outputs 0 immediately, with no release pulse.
   - Deassert `reset` with the button still held. Required: one `btn_press[0]` at the normal latency.
